// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants and result types for the ripple-carry adder instances
// (rca4, rca16, rca32) used throughout the datapath.
package ripple_carry_adder_pkg;

    localparam int RCA_W4  = 4;
    localparam int RCA_W16 = 16;
    localparam int RCA_W32 = 32;

    typedef struct packed {
        logic              cout;
        logic [RCA_W4-1:0] sum;
    } rca4_result_t;

    typedef struct packed {
        logic               cout;
        logic [RCA_W16-1:0] sum;
    } rca16_result_t;

    typedef struct packed {
        logic               cout;
        logic [RCA_W32-1:0] sum;
    } rca32_result_t;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder; one link of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic halfSum;

    assign halfSum = a ^ b;
    assign s       = halfSum ^ cin;
    assign cout    = (a & b) | (cin & halfSum);

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: a chain of full adders feeding a one-cycle
// output register with a valid flag.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = RCA_W32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] coreSum;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             valid_d, valid_q;

    // Carry enters at bit 0 and ripples strictly towards the MSB.
    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (coreSum[i]),
            .cout (carry[i+1])
        );
    end

    // Result registers load only on accepted operands; the flag tracks in_valid.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = coreSum;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench driving 4-, 16- and 32-bit adders in parallel from shared operands and
// checking them against plain integer sums.
module tb_ripple_carry_adder;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        cinIn;

    logic        ov4, co4;
    logic [3:0]  sum4;
    logic        ov16, co16;
    logic [15:0] sum16;
    logic        ov32, co32;
    logic [31:0] sum32;

    logic [4:0]  exp4;
    logic [16:0] exp16;
    logic [32:0] exp32;
    logic        expValid;

    int compared;
    int mismatched;

    ripple_carry_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid),
        .a(aIn[3:0]), .b(bIn[3:0]), .cin(cinIn),
        .out_valid(ov4), .sum(sum4), .cout(co4)
    );

    ripple_carry_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid),
        .a(aIn[15:0]), .b(bIn[15:0]), .cin(cinIn),
        .out_valid(ov16), .sum(sum16), .cout(co16)
    );

    ripple_carry_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid),
        .a(aIn), .b(bIn), .cin(cinIn),
        .out_valid(ov32), .sum(sum32), .cout(co32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact (WIDTH+1)-bit sums captured when operands are accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp4     <= '0;
            exp16    <= '0;
            exp32    <= '0;
            expValid <= 1'b0;
        end else begin
            if (inValid) begin
                exp4  <= 5'(aIn[3:0])   + 5'(bIn[3:0])   + 5'(cinIn);
                exp16 <= 17'(aIn[15:0]) + 17'(bIn[15:0]) + 17'(cinIn);
                exp32 <= 33'(aIn)       + 33'(bIn)       + 33'(cinIn);
            end
            expValid <= inValid;
        end
    end

    task automatic compareResult(input string name, input logic [32:0] act,
                                 input logic actV, input logic [32:0] exp,
                                 input logic expV);
        compared++;
        if (act !== exp || actV !== expV) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got {cout,sum}=%h valid=%b, want %h valid=%b",
                     name, $time, act, actV, exp, expV);
        end
    endtask

    // Every negedge: all three instances must agree with the reference.
    always @(negedge clk) begin
        compareResult("model4",  {28'd0, co4, sum4},   ov4,  {28'd0, exp4},  expValid);
        compareResult("model16", {16'd0, co16, sum16}, ov16, {16'd0, exp16}, expValid);
        compareResult("model32", {co32, sum32},        ov32, exp32,          expValid);
    end

    task automatic applyStimulus(input logic v, input logic [31:0] av,
                                 input logic [31:0] bv, input logic c);
        @(negedge clk);
        inValid = v;
        aIn     = av;
        bIn     = bv;
        cinIn   = c;
    endtask

    // Literal expectation checked against both the DUT and the reference.
    task automatic checkOutput(input string name, input int width,
                               input logic [32:0] want, input logic wantV);
        logic [32:0] act;
        logic [32:0] mdl;
        logic        actV;
        case (width)
            4:       begin act = {28'd0, co4, sum4};   actV = ov4;  mdl = {28'd0, exp4};  end
            16:      begin act = {16'd0, co16, sum16}; actV = ov16; mdl = {16'd0, exp16}; end
            default: begin act = {co32, sum32};        actV = ov32; mdl = exp32;          end
        endcase
        compareResult({name, "_dut"}, act, actV, want, wantV);
        compareResult({name, "_ref"}, mdl, expValid, want, wantV);
    endtask

    task automatic stepAndCheck(input string name, input int width,
                                input logic [31:0] av, input logic [31:0] bv,
                                input logic c, input logic [32:0] want);
        applyStimulus(1'b1, av, bv, c);
        @(posedge clk);
        #1;
        checkOutput(name, width, want, 1'b1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        inValid    = 1'b0;
        aIn        = '0;
        bIn        = '0;
        cinIn      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset4",  4,  33'h0, 1'b0);
        checkOutput("reset32", 32, 33'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back 4-bit operations, then a bubble that must hold the result.
        stepAndCheck("w4_a", 4, 32'hA, 32'h3, 1'b0, {28'd0, 5'b0_1101});
        stepAndCheck("w4_b", 4, 32'hB, 32'h7, 1'b0, {28'd0, 5'b1_0010});
        stepAndCheck("w4_c", 4, 32'hE, 32'h9, 1'b1, {28'd0, 5'b1_1000});
        applyStimulus(1'b0, 32'h5, 32'h5, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("w4_hold", 4, {28'd0, 5'b1_1000}, 1'b0);

        stepAndCheck("w4_ones",  4,  32'hF,    32'hF, 1'b1, {28'd0, 5'b1_1111});
        stepAndCheck("w4_zero",  4,  32'h0,    32'h0, 1'b0, 33'h0);
        stepAndCheck("w16_a",    16, 32'h1EFA, 32'h3FFC, 1'b1, {16'd0, 17'h0_5EF7});
        stepAndCheck("w16_ripl", 16, 32'hFFFF, 32'h0,    1'b1, {16'd0, 17'h1_0000});
        stepAndCheck("w32_a",    32, 32'h9EFA3FFC, 32'hE24029DB, 1'b0, 33'h1_813A69D7);
        stepAndCheck("w32_b",    32, 32'h6893D792, 32'h293CB732, 1'b1, 33'h0_91D08EC5);
        stepAndCheck("w32_ones", 32, 32'hFFFFFFFF, 32'h0,        1'b1, 33'h1_00000000);

        // Asynchronous reset mid-period while out_valid is high.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst4",  4,  33'h0, 1'b0);
        checkOutput("arst16", 16, 33'h0, 1'b0);
        checkOutput("arst32", 32, 33'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stepAndCheck("post_rst", 32, 32'h00000001, 32'h00000002, 1'b1, 33'h0_00000004);

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 15) == 0) ra = 32'hFFFFFFFF;
            if ($urandom_range(0, 15) == 0) rb = 32'h0;
            applyStimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder.md
# ripple_carry_adder

Registered, parameterised ripple-carry adder computing `sum = a + b + cin` with carry-out. It is built from a chain of single-bit full adders. One instance per width serves the 4-, 16- and 32-bit adder roles (`rca4`, `rca16`, `rca32`) in the datapath. Result and carry-out are captured in an output register, so the adder presents a clean one-cycle-latency interface to downstream logic.

## Interface
Parameters:
- `WIDTH`, default 32: operand and sum width. Supported values are 4, 16 and 32; any value ≥ 1 is legal.

Ports:
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `in_valid`, input, 1 bit: operands on `a`/`b`/`cin` are valid this cycle.
- `a`, input, `WIDTH` bits: operand A, unsigned.
- `b`, input, `WIDTH` bits: operand B, unsigned.
- `cin`, input, 1 bit: carry-in.
- `out_valid`, output, 1 bit: `sum`/`cout` hold the result of an accepted operation.
- `sum`, output, `WIDTH` bits: registered `(a + b + cin) mod 2^WIDTH`.
- `cout`, output, 1 bit: registered carry out of bit `WIDTH-1`.

## Operation
- Combinational core: full-adder bit `i` takes `a[i]`, `b[i]` and `c[i]`, where `c[0] = cin`.
  - `s[i] = a[i] ^ b[i] ^ c[i]`
  - `c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))`
  - `cout = c[WIDTH]`
- Carry ripples strictly LSB to MSB. No lookahead and no `+` operator is used for the chain.
- Arithmetic is unsigned. `{cout, sum}` equals the exact `(WIDTH+1)`-bit sum. No overflow flag is produced.
- Rising edge with `in_valid = 1`: `sum` and `cout` load the core outputs, and `out_valid` is set to 1.
- Rising edge with `in_valid = 0`: `sum` and `cout` hold their previous values, and `out_valid` is cleared to 0.
- There is no backpressure. Every valid input is accepted, and a new operand can be accepted every cycle.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on `sum`/`cout`/`out_valid` after edge N.
- Throughput is one operation per cycle.
- Reset values: `sum = 0`, `cout = 0`, `out_valid = 0`.
- Reset is applied immediately on `rst_n` falling, regardless of `clk`. An operation in flight during reset is discarded.
- After `rst_n` rises, the first edge with `in_valid = 1` produces a valid result one cycle later.
- The combinational critical path is `WIDTH` full-adder carry stages. It must close within one clock period at the target frequency.
- Corner cases:
  - All-ones plus `cin = 1`: `sum = 0`, `cout = 1`.
  - Zero plus zero with `cin = 0`: `sum = 0`, `cout = 0`.

## Structure
- Sub-module `full_adder`: 1-bit inputs `a`, `b`, `cin`; outputs `s`, `cout`. The core is a generate loop of `WIDTH` instances.
- A shared package holds:
  - the supported width constants `RCA_W4 = 4`, `RCA_W16 = 16`, `RCA_W32 = 32`;
  - an optional `rca_result_t` struct `{cout, sum}` per width.
- Output register and valid flag live in the top module. No other state exists.

## Test plan
- WIDTH=4, `a=4'b1010`, `b=4'b0011`, `cin=0` -> `sum=4'b1101`, `cout=0`; then `a=4'b1011`, `b=4'b0111`, `cin=0` -> `sum=4'b0010`, `cout=1`; then `a=4'b1110`, `b=4'b1001`, `cin=1` -> `sum=4'b1000`, `cout=1`. Each result appears one cycle after its operands, with `out_valid=1`.
- WIDTH=16, `a=16'h1EFA`, `b=16'h3FFC`, `cin=1` -> `sum=16'h5EF7`, `cout=0`; `a=16'hFFFF`, `b=0`, `cin=1` -> `sum=0`, `cout=1` (full carry ripple).
- WIDTH=32, `a=32'h9EFA3FFC`, `b=32'hE24029DB`, `cin=0` -> `sum=32'h813A69D7`, `cout=1`; `a=32'h6893D792`, `b=32'h293CB732`, `cin=1` -> `sum=32'h91D08EC5`, `cout=0`.
- Back-to-back: three valid operands on consecutive cycles -> three results on consecutive cycles, each one cycle delayed. Deassert `in_valid` -> `out_valid=0` and `sum`/`cout` unchanged.
- Reset: assert `rst_n=0` mid-clock-period while `out_valid=1` -> `sum`, `cout` and `out_valid` go to 0 immediately, without waiting for a clock edge. Release reset and issue one operand -> correct result after one cycle.
- Randomised: 10k random `a`/`b`/`cin` per width, compared against a `(WIDTH+1)`-bit reference sum.
